// File: rtl/ir_nec_decoder_pkg.sv
// ir_pkg: shared types and constants for the NEC IR decoder.
//   ir_state_t  - decoder FSM states
//   CNT_W       - width of the tick duration counter
//   *_MIN/*_MAX - accepted pulse-length windows, in 10 us ticks
//   in_window() - inclusive window test on a measured duration
package ir_pkg;

  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] DUR_MAX = 11'd2047;

  localparam logic [CNT_W-1:0] LEAD_LO_MIN = 11'd800;
  localparam logic [CNT_W-1:0] LEAD_LO_MAX = 11'd1000;
  localparam logic [CNT_W-1:0] LEAD_HI_MIN = 11'd400;
  localparam logic [CNT_W-1:0] LEAD_HI_MAX = 11'd500;
  localparam logic [CNT_W-1:0] REP_HI_MIN  = 11'd180;
  localparam logic [CNT_W-1:0] REP_HI_MAX  = 11'd270;
  localparam logic [CNT_W-1:0] BIT_LO_MIN  = 11'd40;
  localparam logic [CNT_W-1:0] BIT_LO_MAX  = 11'd72;
  localparam logic [CNT_W-1:0] BIT0_MIN    = 11'd40;
  localparam logic [CNT_W-1:0] BIT0_MAX    = 11'd72;
  localparam logic [CNT_W-1:0] BIT1_MIN    = 11'd140;
  localparam logic [CNT_W-1:0] BIT1_MAX    = 11'd200;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LEAD_LO  = 3'd1,
    LEAD_HI  = 3'd2,
    BIT_LO   = 3'd3,
    BIT_HI   = 3'd4,
    STOP     = 3'd5,
    REP_TAIL = 3'd6,
    CHECK    = 3'd7
  } ir_state_t;

  function automatic logic in_window(input logic [CNT_W-1:0] d,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/ir_nec_decoder_pulse_timer.sv
// ir_pulse_timer: front end of the IR decoder.
//   clk, rst (sync, active-low), irda (async, idle high)
//   fall/rise - one-cycle strobes for edges of the synchronised line
//   tick      - one-cycle strobe every TICK_DIV clocks
//   dur       - ticks since the last edge, saturating at DUR_MAX; it is
//               sampled by the consumer in the edge cycle, then cleared
module ir_pulse_timer
  import ir_pkg::*;
#(
  parameter int TICK_DIV = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             irda,
  output logic             fall,
  output logic             rise,
  output logic             tick,
  output logic [CNT_W-1:0] dur
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic          sync1, sync2, level;
  logic [PW-1:0] pre;

  // Two-flop synchroniser, previous-level register and registered edge strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      fall  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= irda;
      sync2 <= sync1;
      level <= sync2;
      fall  <= level & ~sync2;
      rise  <= ~level & sync2;
    end
  end

  // Free-running tick prescaler, restarted by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (pre == PRE_LAST) begin
      pre  <= '0;
      tick <= 1'b1;
    end else begin
      pre  <= pre + PW'(1);
      tick <= 1'b0;
    end
  end

  // Saturating duration counter, cleared in the cycle an edge is presented.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dur <= '0;
    end else if (fall || rise) begin
      dur <= '0;
    end else if (tick && (dur != DUR_MAX)) begin
      dur <= dur + 11'd1;
    end else begin
      dur <= dur;
    end
  end

endmodule

// File: rtl/ir_nec_decoder.sv
// ir_nec_decoder: NEC pulse-distance IR frame decoder with key mapping,
// repeat-code handling and a valid/ready key event output.
//   clk, rst (sync, active-low), irda (async demodulated IR, idle high)
//   key_ready  - consumer accepts the pending event
//   key_valid, key_hit, key_id, key_repeat, cmd, addr - event registers
//   frame_err  - pulse: malformed frame aborted
//   overrun    - pulse: event dropped while a previous one was pending
//   busy       - decoder is inside a frame (LEAD_LO .. CHECK)
// KEY_CODES entry i sits at bits [8i+7:8i]; the default places
// blue=0x1C at entry 0 up to power=0x45 at entry 4.
module ir_nec_decoder
  import ir_pkg::*;
#(
  parameter int                  TICK_DIV      = 500,
  parameter int                  DATA_BITS     = 32,
  parameter int                  CHECK_INV     = 1,
  parameter int                  N_KEYS        = 5,
  parameter logic [N_KEYS*8-1:0] KEY_CODES     = {8'h45, 8'h18, 8'h5E, 8'h0C, 8'h1C},
  parameter int                  REPEAT_EN     = 1,
  parameter int                  REPEAT_WINDOW = 12000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       irda,
  input  logic       key_ready,
  output logic       key_valid,
  output logic       key_hit,
  output logic [3:0] key_id,
  output logic       key_repeat,
  output logic [7:0] cmd,
  output logic [7:0] addr,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int RW_W = $clog2(REPEAT_WINDOW + 1);
  localparam logic [RW_W-1:0] RW_LOAD = RW_W'(REPEAT_WINDOW);
  localparam int BI_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BI_W-1:0] BIT_LAST = BI_W'(DATA_BITS - 1);

  logic             fall, rise, tick, sat;
  logic [CNT_W-1:0] dur;
  ir_state_t        state;
  logic [DATA_BITS-1:0] shreg;
  logic [BI_W-1:0]  bit_idx;
  logic             is_rep;
  logic [RW_W-1:0]  rep_timer;
  logic             have_last, last_hit;
  logic [7:0]       last_addr, last_cmd;
  logic [3:0]       last_id;
  logic [31:0]      word;
  logic [7:0]       frame_addr, frame_cmd;
  logic             inv_ok, lut_hit;
  logic [3:0]       lut_id;
  logic             ev_fire, ev_err, ev_hit, ev_rep;
  logic [7:0]       ev_addr, ev_cmd;
  logic [3:0]       ev_id;

  ir_pulse_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .irda (irda),
    .fall (fall),
    .rise (rise),
    .tick (tick),
    .dur  (dur)
  );

  assign sat        = (dur == DUR_MAX);
  // Bits arrive LSB first, so the first received bit ends up at word[0].
  assign word       = 32'(shreg);
  assign frame_addr = word[7:0];
  assign frame_cmd  = (CHECK_INV != 0) ? word[23:16] : word[15:8];
  assign inv_ok     = (word[15:8] == ~word[7:0]) && (word[31:24] == ~word[23:16]);

  // Command lookup; scanning downwards lets the lowest matching index win.
  always_comb begin
    lut_hit = 1'b0;
    lut_id  = 4'd0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (frame_cmd == KEY_CODES[8*i +: 8]) begin
        lut_hit = 1'b1;
        lut_id  = 4'(i);
      end else begin
      end
    end
  end

  // CHECK-cycle verdict: new event, integrity error, or silent repeat drop.
  always_comb begin
    ev_fire = 1'b0;
    ev_err  = 1'b0;
    ev_addr = frame_addr;
    ev_cmd  = frame_cmd;
    ev_hit  = lut_hit;
    ev_id   = lut_id;
    ev_rep  = 1'b0;
    if (state == CHECK) begin
      if (is_rep) begin
        ev_addr = last_addr;
        ev_cmd  = last_cmd;
        ev_hit  = last_hit;
        ev_id   = last_id;
        ev_rep  = 1'b1;
        ev_fire = have_last && (rep_timer != {RW_W{1'b0}});
      end else if ((CHECK_INV != 0) && !inv_ok) begin
        ev_err = 1'b1;
      end else begin
        ev_fire = 1'b1;
      end
    end else begin
    end
  end

  // Decoder FSM, repeat window, last-key store and output handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      is_rep     <= 1'b0;
      rep_timer  <= '0;
      have_last  <= 1'b0;
      last_hit   <= 1'b0;
      last_id    <= 4'd0;
      last_addr  <= 8'd0;
      last_cmd   <= 8'd0;
      key_valid  <= 1'b0;
      key_hit    <= 1'b0;
      key_id     <= 4'd0;
      key_repeat <= 1'b0;
      cmd        <= 8'd0;
      addr       <= 8'd0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      if (ev_fire) begin
        rep_timer <= RW_LOAD;
      end else if (tick && (rep_timer != {RW_W{1'b0}})) begin
        rep_timer <= rep_timer - RW_W'(1);
      end

      if (ev_fire && !is_rep) begin
        have_last <= 1'b1;
        last_addr <= ev_addr;
        last_cmd  <= ev_cmd;
        last_hit  <= ev_hit;
        last_id   <= ev_id;
      end

      // A new event may load in the same cycle as a transfer.
      if (ev_fire) begin
        if (!key_valid || key_ready) begin
          key_valid  <= 1'b1;
          key_hit    <= ev_hit;
          key_id     <= ev_id;
          key_repeat <= ev_rep;
          cmd        <= ev_cmd;
          addr       <= ev_addr;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (fall) begin
            state <= LEAD_LO;
            busy  <= 1'b1;
          end
        end
        LEAD_LO: begin
          if (rise && in_window(dur, LEAD_LO_MIN, LEAD_LO_MAX)) begin
            state <= LEAD_HI;
          end else if (rise || sat) begin
            state <= IDLE; busy <= 1'b0; frame_err <= 1'b1;
          end
        end
        LEAD_HI: begin
          if (fall && in_window(dur, LEAD_HI_MIN, LEAD_HI_MAX)) begin
            state   <= BIT_LO;
            bit_idx <= '0;
            is_rep  <= 1'b0;
          end else if (fall && (REPEAT_EN != 0) && in_window(dur, REP_HI_MIN, REP_HI_MAX)) begin
            state  <= REP_TAIL;
            is_rep <= 1'b1;
          end else if (fall || sat) begin
            state <= IDLE; busy <= 1'b0; frame_err <= 1'b1;
          end
        end
        BIT_LO: begin
          if (rise && in_window(dur, BIT_LO_MIN, BIT_LO_MAX)) begin
            state <= BIT_HI;
          end else if (rise || sat) begin
            state <= IDLE; busy <= 1'b0; frame_err <= 1'b1;
          end
        end
        BIT_HI: begin
          if (fall && (in_window(dur, BIT0_MIN, BIT0_MAX) || in_window(dur, BIT1_MIN, BIT1_MAX))) begin
            shreg <= {in_window(dur, BIT1_MIN, BIT1_MAX), shreg[DATA_BITS-1:1]};
            if (bit_idx == BIT_LAST) begin
              state <= CHECK;
            end else begin
              bit_idx <= bit_idx + BI_W'(1);
              state   <= BIT_LO;
            end
          end else if (fall || sat) begin
            state <= IDLE; busy <= 1'b0; frame_err <= 1'b1;
          end
        end
        REP_TAIL: begin
          if (rise && in_window(dur, BIT_LO_MIN, BIT_LO_MAX)) begin
            state <= CHECK;
          end else if (rise || sat) begin
            state <= IDLE; busy <= 1'b0; frame_err <= 1'b1;
          end
        end
        CHECK: begin
          state     <= IDLE;
          busy      <= 1'b0;
          frame_err <= ev_err;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_nec_decoder.sv
module tb_ir_nec_decoder;

  localparam int TICK_DIV = 2;
  localparam int RPT_WIN  = 1500;
  localparam logic [39:0] CODES = {8'h45, 8'h18, 8'h5E, 8'h0C, 8'h1C};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       irda = 1'b1;
  logic       key_ready = 1'b1;
  logic       key_valid, key_hit, key_repeat, frame_err, overrun, busy;
  logic [3:0] key_id;
  logic [7:0] cmd, addr;

  ir_nec_decoder #(
    .TICK_DIV(TICK_DIV), .DATA_BITS(32), .CHECK_INV(1), .N_KEYS(5),
    .KEY_CODES(CODES), .REPEAT_EN(1), .REPEAT_WINDOW(RPT_WIN)
  ) dut (
    .clk(clk), .rst(rst), .irda(irda), .key_ready(key_ready),
    .key_valid(key_valid), .key_hit(key_hit), .key_id(key_id),
    .key_repeat(key_repeat), .cmd(cmd), .addr(addr),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] cmd;
    logic       hit;
    logic [3:0] id;
    logic       rep;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  n_ev = 0;
  int  n_err = 0;
  int  n_ovr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_event(input logic [7:0] a, input logic [7:0] c,
                              input logic h, input logic [3:0] i, input logic r);
    ev_t e;
    e.addr = a; e.cmd = c; e.hit = h; e.id = i; e.rep = r;
    sb.push_back(e);
  endtask

  task automatic hold(input logic lvl, input int ticks);
    irda = lvl;
    repeat (ticks * TICK_DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_leader();
    hold(1'b0, 850);
    hold(1'b1, 430);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      hold(1'b0, 50);
      hold(1'b1, w[i] ? 150 : 50);
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] b3);
    send_leader();
    send_bits({b3, c, ~a, a}, 32);
    hold(1'b0, 50);
    hold(1'b1, 100);
  endtask

  task automatic send_repeat();
    hold(1'b0, 850);
    hold(1'b1, 200);
    hold(1'b0, 50);
    hold(1'b1, 20);
  endtask

  // Monitor: counts pulses and scores every transferred event.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err) n_err++;
      if (overrun) n_ovr++;
      if (key_valid && key_ready) begin
        n_ev++;
        if (sb.size() == 0) begin
          check("event_expected", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          check("ev_addr", 32'(addr), 32'(mon_e.addr));
          check("ev_cmd", 32'(cmd), 32'(mon_e.cmd));
          check("ev_hit", 32'(key_hit), 32'(mon_e.hit));
          check("ev_id", 32'(key_id), 32'(mon_e.id));
          check("ev_repeat", 32'(key_repeat), 32'(mon_e.rep));
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    irda = 1'b1;
    key_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({key_valid, key_hit, key_id, key_repeat, cmd, addr,
                              frame_err, overrun, busy}), 32'd0);
    rst = 1'b1;
    hold(1'b1, 20);

    // Valid frame, cmd 0x45 -> key 4
    expect_event(8'h00, 8'h45, 1'b1, 4'd4, 1'b0);
    send_frame(8'h00, 8'h45, 8'hBA);
    hold(1'b1, 100);
    check("frame_events", 32'(n_ev), 32'd1);
    check("frame_no_err", 32'(n_err), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);

    // Repeat inside the window
    expect_event(8'h00, 8'h45, 1'b1, 4'd4, 1'b1);
    send_repeat();
    check("repeat_events", 32'(n_ev), 32'd2);

    // Repeat after the window expired: silently dropped
    hold(1'b1, 600);
    send_repeat();
    check("late_repeat_events", 32'(n_ev), 32'd2);
    check("late_repeat_no_err", 32'(n_err), 32'd0);

    // Broken complement byte
    send_frame(8'h00, 8'h45, 8'h00);
    check("inv_err", 32'(n_err), 32'd1);
    check("inv_no_event", 32'(n_ev), 32'd2);

    // Short leader
    hold(1'b0, 600);
    hold(1'b1, 100);
    check("short_lead_err", 32'(n_err), 32'd2);
    check("short_lead_busy", 32'(busy), 32'd0);

    // Line stuck low until the counter saturates
    hold(1'b0, 1000);
    check("stuck_busy_mid", 32'(busy), 32'd1);
    hold(1'b0, 1100);
    check("stuck_err", 32'(n_err), 32'd3);
    check("stuck_busy_end", 32'(busy), 32'd0);
    hold(1'b1, 100);
    check("stuck_busy_high", 32'(busy), 32'd0);

    // Reset during bit 15
    send_leader();
    send_bits({8'hBA, 8'h45, 8'hFF, 8'h00}, 15);
    hold(1'b0, 20);
    check("mid_frame_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_outputs", 32'({key_valid, key_hit, key_id, key_repeat, cmd, addr,
                                    frame_err, overrun, busy}), 32'd0);
    hold(1'b1, 50);
    rst = 1'b1;
    hold(1'b1, 100);
    check("mid_reset_no_err", 32'(n_err), 32'd3);

    // Unmapped cmd held with key_ready low
    key_ready = 1'b0;
    expect_event(8'h00, 8'h77, 1'b0, 4'd0, 1'b0);
    send_frame(8'h00, 8'h77, 8'h88);
    check("held_valid", 32'(key_valid), 32'd1);
    check("held_cmd", 32'(cmd), 32'h77);
    check("held_hit", 32'(key_hit), 32'd0);
    check("held_id", 32'(key_id), 32'd0);

    // Second frame while pending -> overrun, first kept
    send_frame(8'h00, 8'h1C, 8'hE3);
    check("overrun_count", 32'(n_ovr), 32'd1);
    check("overrun_valid", 32'(key_valid), 32'd1);
    check("overrun_kept_cmd", 32'(cmd), 32'h77);

    // Release the consumer: first event transfers, valid drops
    key_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid_drop", 32'(key_valid), 32'd0);
    hold(1'b1, 20);
    check("release_events", 32'(n_ev), 32'd3);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("final_err_count", 32'(n_err), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
